// File: rtl/trap_ctrl.sv
// trap_ctrl: trap and redirect controller at the far end of writeback.
//
// Watches retire/exception/flush status from writeback and raises csr_kill
// to squash younger work. If a cache bus transaction is in flight
// (wb_stall), it waits until the transaction completes. It then captures
// mepc/mcause for exceptions and issues a one-cycle fetch redirect. It also
// owns mtvec, mepc, mcause and the 64-bit minstret counter behind a simple
// CSR port.
//
// Ports:
//   clk_core, reset_n          core clock, async active-low reset
//   wb_valid/wb_exc/wb_flush   writeback status
//   wb_exc_cause               exception code (4 bits)
//   wb_pc                      pc[31:2] of the writeback instruction
//   wb_stall                   writeback frozen behind a bus transaction
//   csr_kill                   squash mem1->wb transfer and younger stages
//   redir_valid, redir_pc      one-cycle fetch redirect strobe and target
//   csr_addr/we/wdata/rdata    CSR access port; rdata is combinational
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | no trap pending
//   ST_HOLD  | event seen while stalled; wb_* inputs are frozen
//   ST_REDIR | redirect strobe high this cycle; new events are ignored
module trap_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  logic [3:0]  wb_exc_cause,
  input  logic        wb_flush,
  input  logic [29:0] wb_pc,
  input  logic        wb_stall,
  output logic        csr_kill,
  output logic        redir_valid,
  output logic [29:0] redir_pc,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MINST_LO = 12'hB02;
  localparam logic [11:0] ADDR_MINST_HI = 12'hB82;
  localparam logic [11:0] ADDR_INST_LO  = 12'hC02;
  localparam logic [11:0] ADDR_INST_HI  = 12'hC82;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t      state_q;
  logic        redir_valid_q;
  logic [29:0] redir_pc_q;

  logic [29:0] mtvec_q;
  logic [29:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] minst_lo_q, minst_lo_d;
  logic [31:0] minst_hi_q, minst_hi_d;

  logic        evt;
  logic        capture;
  logic        trap_exc;
  logic [29:0] target;
  logic        inc;
  logic [32:0] lo_sum;

  logic wr_mtvec, wr_mepc, wr_mcause, wr_lo, wr_hi;

  assign evt      = wb_exc | (wb_valid & wb_flush);
  assign csr_kill = evt | (state_q != ST_IDLE);

  // In HOLD the writeback registers are frozen, so the event kind is still
  // readable from the live inputs at the moment the stall clears.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      ST_IDLE: capture = evt & ~wb_stall;
      ST_HOLD: capture = ~wb_stall;
      default: capture = 1'b0;
    endcase
  end

  assign trap_exc = capture & wb_exc;
  // Exception wins over flush; flush target wraps naturally at 30 bits.
  assign target   = wb_exc ? mtvec_q : (wb_pc + 30'd1);

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 30'd0;
    end else begin
      redir_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (evt) begin
            if (wb_stall) begin
              state_q <= ST_HOLD;
            end else begin
              state_q       <= ST_REDIR;
              redir_valid_q <= 1'b1;
              redir_pc_q    <= target;
            end
          end
        end
        ST_HOLD: begin
          if (!wb_stall) begin
            state_q       <= ST_REDIR;
            redir_valid_q <= 1'b1;
            redir_pc_q    <= target;
          end
        end
        ST_REDIR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;

  assign wr_mtvec  = csr_we & (csr_addr == ADDR_MTVEC);
  assign wr_mepc   = csr_we & (csr_addr == ADDR_MEPC);
  assign wr_mcause = csr_we & (csr_addr == ADDR_MCAUSE);
  assign wr_lo     = csr_we & (csr_addr == ADDR_MINST_LO);
  assign wr_hi     = csr_we & (csr_addr == ADDR_MINST_HI);

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mtvec_q <= RESET_MTVEC[31:2];
    end else if (wr_mtvec) begin
      mtvec_q <= csr_wdata[31:2];
    end
  end

  // A trap capture takes precedence over a software write in the same cycle.
  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      mepc_q   <= 30'd0;
      mcause_q <= 32'd0;
    end else if (trap_exc) begin
      mepc_q   <= wb_pc;
      mcause_q <= {28'd0, wb_exc_cause};
    end else begin
      if (wr_mepc)   mepc_q   <= csr_wdata[31:2];
      if (wr_mcause) mcause_q <= csr_wdata;
    end
  end

  // A write to one half replaces that half's increment, but the carry out
  // of the old low word still reaches the high word when only low is written.
  assign inc    = wb_valid & ~wb_stall;
  assign lo_sum = {1'b0, minst_lo_q} + {32'd0, inc};

  always_comb begin
    minst_lo_d = lo_sum[31:0];
    minst_hi_d = minst_hi_q + {31'd0, lo_sum[32]};
    if (wr_lo) minst_lo_d = csr_wdata;
    if (wr_hi) minst_hi_d = csr_wdata;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      minst_lo_q <= 32'd0;
      minst_hi_q <= 32'd0;
    end else begin
      minst_lo_q <= minst_lo_d;
      minst_hi_q <= minst_hi_d;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
      ADDR_MEPC:     csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MINST_LO: csr_rdata = minst_lo_q;
      ADDR_MINST_HI: csr_rdata = minst_hi_q;
      ADDR_INST_LO:  csr_rdata = minst_lo_q;
      ADDR_INST_HI:  csr_rdata = minst_hi_q;
      default:       csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
module tb_trap_ctrl;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        wb_valid, wb_exc, wb_flush, wb_stall;
  logic [3:0]  wb_exc_cause;
  logic [29:0] wb_pc;
  logic        csr_kill, redir_valid;
  logic [29:0] redir_pc;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata, csr_rdata;

  int errors = 0;
  int checks = 0;

  logic [29:0] exp_q[$];
  logic [29:0] obs_q[$];

  trap_ctrl #(.RESET_MTVEC(32'h0000_0107)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
    .wb_flush(wb_flush), .wb_pc(wb_pc), .wb_stall(wb_stall),
    .csr_kill(csr_kill), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  always #10 clk_core = ~clk_core;

  // Redirect monitor: records every strobe observed mid-cycle.
  always @(negedge clk_core) begin
    if (redir_valid === 1'b1) obs_q.push_back(redir_pc);
  end

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, 64'(csr_rdata), 64'(exp));
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_addr  = a;
    csr_wdata = d;
    csr_we    = 1'b1;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic check_redirs(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_pc"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    wb_valid = 0; wb_exc = 0; wb_flush = 0; wb_stall = 0;
    wb_exc_cause = 4'd0; wb_pc = 30'd0;
    csr_addr = 12'd0; csr_we = 0; csr_wdata = 32'd0;
    #25 reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_redir_valid", 64'(redir_valid), 64'(0));
    chk("rst_redir_pc", 64'(redir_pc), 64'(0));
    chk("rst_kill", 64'(csr_kill), 64'(0));
    rd_chk("rst_mtvec", 12'h305, 32'h104);
    rd_chk("rst_mepc", 12'h341, 32'h0);
    rd_chk("rst_mcause", 12'h342, 32'h0);
    rd_chk("rst_minst_lo", 12'hB02, 32'h0);
    rd_chk("rst_minst_hi", 12'hB82, 32'h0);

    // Unstalled exception
    csr_wr(12'h305, 32'h80);
    wb_exc = 1; wb_exc_cause = 4'd2; wb_pc = 30'h100; wb_stall = 0;
    exp_q.push_back(30'h20);
    #1 chk("exc_kill_same_cycle", 64'(csr_kill), 64'(1));
    tick();
    wb_exc = 0;
    chk("exc_redir_valid", 64'(redir_valid), 64'(1));
    chk("exc_redir_pc", 64'(redir_pc), 64'(30'h20));
    chk("exc_kill_redir", 64'(csr_kill), 64'(1));
    rd_chk("exc_mepc", 12'h341, 32'h400);
    rd_chk("exc_mcause", 12'h342, 32'h2);
    tick();
    chk("exc_redir_drop", 64'(redir_valid), 64'(0));
    chk("exc_kill_drop", 64'(csr_kill), 64'(0));
    check_redirs("exc");

    // Stalled exception
    wb_exc = 1; wb_exc_cause = 4'd5; wb_pc = 30'h200; wb_stall = 1;
    exp_q.push_back(30'h20);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_kill", 64'(csr_kill), 64'(1));
      chk("hold_no_redir", 64'(redir_valid), 64'(0));
      tick();
    end
    wb_stall = 0;
    #1 chk("hold_kill_release", 64'(csr_kill), 64'(1));
    chk("hold_no_redir_release", 64'(redir_valid), 64'(0));
    tick();
    wb_exc = 0;
    chk("hold_redir_valid", 64'(redir_valid), 64'(1));
    chk("hold_redir_pc", 64'(redir_pc), 64'(30'h20));
    tick();
    chk("hold_redir_drop", 64'(redir_valid), 64'(0));
    rd_chk("hold_mepc", 12'h341, 32'h800);
    rd_chk("hold_mcause", 12'h342, 32'h5);
    check_redirs("hold");

    // Flush without valid is not an event
    wb_flush = 1;
    #1 chk("flush_novalid_kill", 64'(csr_kill), 64'(0));
    wb_flush = 0;
    tick();

    // Flush with pc wrap
    wb_valid = 1; wb_flush = 1; wb_pc = 30'h3FFF_FFFF;
    exp_q.push_back(30'h0);
    #1 chk("flush_kill", 64'(csr_kill), 64'(1));
    tick();
    wb_valid = 0; wb_flush = 0;
    chk("flush_redir_valid", 64'(redir_valid), 64'(1));
    chk("flush_redir_pc", 64'(redir_pc), 64'(0));
    rd_chk("flush_mepc", 12'h341, 32'h800);
    rd_chk("flush_mcause", 12'h342, 32'h5);
    rd_chk("flush_minst_lo", 12'hB02, 32'h1);
    rd_chk("flush_minst_hi", 12'hB82, 32'h0);
    tick();
    check_redirs("flush");

    // Counter carry
    csr_wr(12'hB02, 32'hFFFF_FFFF);
    csr_wr(12'hB82, 32'h0);
    wb_valid = 1;
    tick();
    wb_valid = 0;
    rd_chk("cnt_lo", 12'hB02, 32'h0);
    rd_chk("cnt_hi", 12'hB82, 32'h1);
    rd_chk("cnt_shadow_lo", 12'hC02, 32'h0);
    rd_chk("cnt_shadow_hi", 12'hC82, 32'h1);
    csr_wr(12'hC02, 32'h55);
    rd_chk("cnt_shadow_wr_ignored", 12'hC02, 32'h0);
    rd_chk("cnt_lo_after_shadow_wr", 12'hB02, 32'h0);

    // Write-vs-increment collisions
    csr_wr(12'hB02, 32'hFFFF_FFFF);
    csr_wr(12'hB82, 32'h7);
    wb_valid = 1;
    csr_wr(12'hB02, 32'h3);
    wb_valid = 0;
    rd_chk("col_lo_write_wins", 12'hB02, 32'h3);
    rd_chk("col_hi_carry_kept", 12'hB82, 32'h8);
    wb_valid = 1;
    csr_wr(12'hB82, 32'h9);
    wb_valid = 0;
    rd_chk("col_lo_inc", 12'hB02, 32'h4);
    rd_chk("col_hi_write_wins", 12'hB82, 32'h9);

    // 64-bit wrap
    csr_wr(12'hB02, 32'hFFFF_FFFF);
    csr_wr(12'hB82, 32'hFFFF_FFFF);
    wb_valid = 1;
    tick();
    wb_valid = 0;
    rd_chk("wrap_lo", 12'hB02, 32'h0);
    rd_chk("wrap_hi", 12'hB82, 32'h0);

    // CSR map details
    csr_wr(12'h123, 32'hDEAD_BEEF);
    rd_chk("unmapped_rd", 12'h123, 32'h0);
    csr_wr(12'h305, 32'h87);
    rd_chk("mtvec_low_bits", 12'h305, 32'h84);
    csr_wr(12'h305, 32'h80);
    csr_wr(12'h341, 32'h1237);
    rd_chk("mepc_low_bits", 12'h341, 32'h1234);
    csr_wr(12'h342, 32'hFFFF_FFFF);
    rd_chk("mcause_full", 12'h342, 32'hFFFF_FFFF);

    // Trap capture beats CSR write to mepc
    csr_addr = 12'h341; csr_wdata = 32'h1234; csr_we = 1;
    wb_exc = 1; wb_exc_cause = 4'd3; wb_pc = 30'h40;
    exp_q.push_back(30'h20);
    tick();
    csr_we = 0; wb_exc = 0;
    chk("col_trap_redir", 64'(redir_valid), 64'(1));
    rd_chk("col_trap_mepc", 12'h341, 32'h100);
    rd_chk("col_trap_mcause", 12'h342, 32'h3);
    tick();
    check_redirs("col_trap");

    // Reset in HOLD
    wb_exc = 1; wb_exc_cause = 4'd7; wb_pc = 30'h10; wb_stall = 1;
    tick();
    tick();
    chk("rhold_kill", 64'(csr_kill), 64'(1));
    reset_n = 1'b0;
    #1;
    wb_exc = 0; wb_stall = 0;
    #1 chk("rhold_kill_in_reset", 64'(csr_kill), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("rhold_redir_valid", 64'(redir_valid), 64'(0));
    chk("rhold_redir_pc", 64'(redir_pc), 64'(0));
    chk("rhold_kill_after", 64'(csr_kill), 64'(0));
    rd_chk("rhold_mtvec", 12'h305, 32'h104);
    rd_chk("rhold_mepc", 12'h341, 32'h0);
    rd_chk("rhold_mcause", 12'h342, 32'h0);
    rd_chk("rhold_minst_lo", 12'hC02, 32'h0);
    rd_chk("rhold_minst_hi", 12'hC82, 32'h0);
    check_redirs("rhold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and redirect controller sitting at the far end of the writeback interface. It consumes the retire/exception/flush status that writeback presents and returns `csr_kill` to squash younger work. It waits out any in-flight cache bus transaction, then captures `mepc`/`mcause` and issues a one-cycle fetch redirect. It also owns `mtvec`, `mepc`, `mcause` and the 64-bit `minstret` counter behind a simple CSR access port.

## Interface
- `RESET_MTVEC`, default 32'h0000_0000: reset value of `mtvec`; bits [1:0] ignored.
- `clk_core` in 1: core clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: writeback holds a retiring instruction.
- `wb_exc` in 1: writeback holds an excepting instruction.
- `wb_exc_cause` in ecause_t (4): exception code.
- `wb_flush` in 1: retiring instruction requests a pipeline flush (refetch at next pc).
- `wb_pc` in 30: pc[31:2] of the writeback instruction.
- `wb_stall` in 1: writeback frozen, because fetch1 or mem1 is mid bus transaction.
- `csr_kill` out 1: squash mem1→writeback transfer and younger stages.
- `redir_valid` out 1: one-cycle fetch redirect strobe.
- `redir_pc` out 30: redirect target pc[31:2].
- `csr_addr` in 12: CSR address.
- `csr_we` in 1: CSR write strobe.
- `csr_wdata` in 32: CSR write data.
- `csr_rdata` out 32: CSR read data, combinational from `csr_addr`.

## Operation
- Event = `wb_exc | (wb_valid & wb_flush)`. Exception has priority when both are set.
- FSM states:
  - IDLE
    - Event & `wb_stall` → HOLD.
    - Event & ~`wb_stall` → capture, → REDIR.
  - HOLD
    - Writeback registers are frozen, so the wb_* inputs stay stable.
    - On ~`wb_stall` → capture, → REDIR.
  - REDIR
    - `redir_valid`=1 for exactly this cycle.
    - → IDLE unconditionally; events are ignored in this cycle.
- Capture, exception:
  - `mepc` ← {`wb_pc`,2'b0}.
  - `mcause` ← {28'b0,`wb_exc_cause`}; bit 31 = 0, no interrupts.
  - `redir_pc` ← `mtvec`[31:2] (direct mode only).
- Capture, flush:
  - `redir_pc` ← `wb_pc`+1, modulo 2^30, so 30'h3FFF_FFFF wraps to 0.
  - `mepc` and `mcause` are unchanged.
- `csr_kill` = Event | (state != IDLE). Combinational.
- `minstret`, 64-bit:
  - +1 on `wb_valid & ~wb_stall`, including flush instructions.
  - Carries into the high word and wraps 2^64−1 → 0.
- CSR map:
  - 0x305 `mtvec`: RW, bits [1:0] read 0.
  - 0x341 `mepc`: RW, bits [1:0] read 0.
  - 0x342 `mcause`: RW, full 32 bits.
  - 0xB02 / 0xB82 `minstret` low/high: RW.
  - 0xC02 / 0xC82: read-only shadows; writes ignored.
  - Any other address reads 0 and ignores writes.
- Collisions in the same cycle:
  - Trap capture beats a CSR write to `mepc`/`mcause`.
  - A CSR write to either `minstret` half beats the increment of that half. A carry into the half not being written still applies.

## Timing
- Reset values:
  - state IDLE.
  - `redir_valid` 0, `redir_pc` 0.
  - `mtvec` `RESET_MTVEC` & ~3.
  - `mepc` 0, `mcause` 0, `minstret` 0.
  - `csr_kill` follows its equation with state=IDLE.
- Reset asserted mid-HOLD or mid-REDIR aborts immediately; no redirect is issued.
- Latency from the event cycle with ~`wb_stall` to `redir_valid`: 1 cycle. With stall: 1 cycle after the first ~`wb_stall` cycle.
- CSR registers update on the edge after `csr_we`. `csr_rdata` shows the new value the following cycle.
- `csr_kill` is asserted in the event cycle itself and stays high through REDIR.

## Test plan
- Unstalled exception:
  - Stimulus: `mtvec`=0x80, `wb_exc`=1, cause=2, `wb_pc`=0x100 (byte 0x400), `wb_stall`=0.
  - Expect: `csr_kill` high the same cycle; next cycle `redir_valid`=1, `redir_pc`=0x20, `mepc`=0x400, `mcause`=2.
- Stalled exception:
  - Stimulus: `wb_stall`=1 for 5 cycles alongside `wb_exc`.
  - Expect: FSM stays in HOLD; `csr_kill` high throughout; `redir_valid` asserts exactly 1 cycle after `wb_stall` falls.
- Flush wrap:
  - Stimulus: `wb_valid`=`wb_flush`=1, `wb_pc`=30'h3FFF_FFFF.
  - Expect: `redir_pc`=0; `mepc`/`mcause` unchanged; `minstret` +1.
- Counter:
  - Stimulus: preload `minstret` low=0xFFFF_FFFF, high=0; then 1 retire.
  - Expect: reads 0xB02=0, 0xB82=1; 0xC82=1.
  - Write to 0xC02 leaves the value unchanged.
- Collision:
  - Stimulus: CSR write `mepc`=0x1234 in the same cycle as a trap capture with `wb_pc`=0x40.
  - Expect: `mepc`=0x100.
- Reset mid-HOLD:
  - Stimulus: assert `reset_n` low while in HOLD.
  - Expect: `redir_valid` never pulses; all registers read their reset values.
